// File: rtl/ble_pdu_deframer.sv
// BLE PDU deframer: bit sampling, LSB-first byte assembly, header parse and CRC-24 check.
// Define BLE_DEFRAMER_ERR_CNT_EN to add the saturating err_count output.
module ble_pdu_deframer #(
  parameter int unsigned BIT_PERIOD    = 50,
  parameter int unsigned SAMPLE_OFFSET = 1,
  parameter int unsigned MAX_LEN       = 37,
  parameter logic [23:0] CRC_INIT      = 24'h555555
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        trigger,
  input  logic        bit_in,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic [7:0]  byte_index,
  output logic        hdr_valid,
  output logic [3:0]  pdu_type,
  output logic [7:0]  pdu_len,
  output logic        pkt_done,
  output logic        crc_ok,
  output logic        len_err,
`ifdef BLE_DEFRAMER_ERR_CNT_EN
  output logic [15:0] err_count,
`endif
  output logic        pkt_abort
);

  localparam int unsigned PHASE_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [23:0] CRC_POLY = 24'h00065B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_CRC,
    S_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [6:0]          sreg_q, sreg_d;
  logic [10:0]         bit_cnt_q, bit_cnt_d;
  logic [23:0]         crc_q, crc_d;
  logic [22:0]         rx_crc_q, rx_crc_d;
  logic [7:0]          byte_out_q, byte_out_d;
  logic                byte_valid_q, byte_valid_d;
  logic [7:0]          byte_index_q, byte_index_d;
  logic                hdr_valid_q, hdr_valid_d;
  logic [3:0]          pdu_type_q, pdu_type_d;
  logic [7:0]          pdu_len_q, pdu_len_d;
  logic                pkt_done_q, pkt_done_d;
  logic                crc_ok_q, crc_ok_d;
  logic                len_err_q, len_err_d;
  logic                pkt_abort_q, pkt_abort_d;

  logic                sample;
  logic [7:0]          byte_nxt;
  logic                byte_end;
  logic                hdr_end;
  logic                pay_end;
  logic                crc_end;
  logic                len_bad;

  function automatic logic [23:0] crc_next(input logic [23:0] c, input logic b);
    logic fb;
    fb = c[23] ^ b;
    return {c[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h000000);
  endfunction

  assign sample   = trigger && (phase_q == PHASE_W'(SAMPLE_OFFSET));
  assign byte_nxt = {bit_in, sreg_q};
  assign byte_end = (bit_cnt_q[2:0] == 3'd7);
  assign hdr_end  = (state_q == S_HEADER) && (bit_cnt_q == 11'd15);
  assign pay_end  = ((bit_cnt_q + 11'd1) == {pdu_len_q, 3'b000});
  assign crc_end  = (bit_cnt_q == 11'd23);
  assign len_bad  = (byte_nxt > 8'(MAX_LEN));

  // State register
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: each combinational output is defaulted first so no latch is inferred on unlisted paths.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (sample) state_d = S_HEADER;
      end
      S_HEADER: begin
        if (!trigger) begin
          state_d = S_IDLE;
        end else if (sample && hdr_end) begin
          if (len_bad)               state_d = S_WAIT;
          else if (byte_nxt == 8'd0) state_d = S_CRC;
          else                       state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (!trigger)               state_d = S_IDLE;
        else if (sample && pay_end) state_d = S_CRC;
      end
      S_CRC: begin
        if (!trigger)               state_d = S_IDLE;
        else if (sample && crc_end) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!trigger) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output logic
  always_comb begin
    phase_d      = (!trigger || (phase_q == PHASE_W'(BIT_PERIOD - 1))) ? '0 : phase_q + PHASE_W'(1);
    sreg_d       = sreg_q;
    bit_cnt_d    = bit_cnt_q;
    crc_d        = crc_q;
    rx_crc_d     = rx_crc_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    byte_index_d = byte_index_q;
    hdr_valid_d  = 1'b0;
    pdu_type_d   = pdu_type_q;
    pdu_len_d    = pdu_len_q;
    pkt_done_d   = 1'b0;
    crc_ok_d     = crc_ok_q;
    len_err_d    = len_err_q;
    pkt_abort_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The sample that starts a packet is also the first header bit.
        if (sample) begin
          sreg_d       = byte_nxt[7:1];
          bit_cnt_d    = 11'd1;
          crc_d        = crc_next(CRC_INIT, bit_in);
          crc_ok_d     = 1'b0;
          len_err_d    = 1'b0;
          byte_index_d = 8'd0;
        end
      end
      S_HEADER, S_PAYLOAD: begin
        if (!trigger) begin
          pkt_abort_d = 1'b1;
        end else if (sample) begin
          sreg_d    = byte_nxt[7:1];
          crc_d     = crc_next(crc_q, bit_in);
          bit_cnt_d = bit_cnt_q + 11'd1;
          if (byte_end) begin
            byte_out_d   = byte_nxt;
            byte_valid_d = 1'b1;
            byte_index_d = (state_q == S_HEADER) ? {7'd0, bit_cnt_q[3]}
                                                 : 8'd2 + bit_cnt_q[10:3];
          end
          if (hdr_end) begin
            // byte_out_q still holds header byte0 on the edge that completes byte1.
            hdr_valid_d = 1'b1;
            pdu_type_d  = byte_out_q[3:0];
            pdu_len_d   = byte_nxt;
            bit_cnt_d   = 11'd0;
            if (len_bad) begin
              pkt_done_d = 1'b1;
              len_err_d  = 1'b1;
              crc_ok_d   = 1'b0;
            end
          end
          if ((state_q == S_PAYLOAD) && pay_end) bit_cnt_d = 11'd0;
        end
      end
      S_CRC: begin
        if (!trigger) begin
          pkt_abort_d = 1'b1;
        end else if (sample) begin
          rx_crc_d  = {rx_crc_q[21:0], bit_in};
          bit_cnt_d = bit_cnt_q + 11'd1;
          if (crc_end) begin
            // rx_crc_q holds the first 23 CRC bits; the 24th comes straight from bit_in.
            pkt_done_d = 1'b1;
            crc_ok_d   = ({rx_crc_q, bit_in} == crc_q);
            bit_cnt_d  = 11'd0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      phase_q      <= '0;
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      crc_q        <= CRC_INIT;
      rx_crc_q     <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_index_q <= '0;
      hdr_valid_q  <= 1'b0;
      pdu_type_q   <= '0;
      pdu_len_q    <= '0;
      pkt_done_q   <= 1'b0;
      crc_ok_q     <= 1'b0;
      len_err_q    <= 1'b0;
      pkt_abort_q  <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      sreg_q       <= sreg_d;
      bit_cnt_q    <= bit_cnt_d;
      crc_q        <= crc_d;
      rx_crc_q     <= rx_crc_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      byte_index_q <= byte_index_d;
      hdr_valid_q  <= hdr_valid_d;
      pdu_type_q   <= pdu_type_d;
      pdu_len_q    <= pdu_len_d;
      pkt_done_q   <= pkt_done_d;
      crc_ok_q     <= crc_ok_d;
      len_err_q    <= len_err_d;
      pkt_abort_q  <= pkt_abort_d;
    end
  end

`ifdef BLE_DEFRAMER_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (pkt_done_d && (!crc_ok_d || len_err_d) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign byte_index = byte_index_q;
  assign hdr_valid  = hdr_valid_q;
  assign pdu_type   = pdu_type_q;
  assign pdu_len    = pdu_len_q;
  assign pkt_done   = pkt_done_q;
  assign crc_ok     = crc_ok_q;
  assign len_err    = len_err_q;
  assign pkt_abort  = pkt_abort_q;

endmodule

// File: tb/tb_ble_pdu_deframer.sv
// Scoreboard bench for ble_pdu_deframer: expected strobes are queued as bits are driven and
// matched (value and edge) when the DUT raises them. Define BLE_DEFRAMER_ERR_CNT_EN to cover err_count.
module tb_ble_pdu_deframer;

  localparam int          BIT_PERIOD    = 50;
  localparam int          SAMPLE_OFFSET = 1;
  localparam int          MAX_LEN       = 37;
  localparam logic [23:0] CRC_INIT      = 24'h555555;

  logic       clock   = 1'b0;
  logic       reset   = 1'b0;
  logic       trigger = 1'b0;
  logic       bit_in  = 1'b0;
  logic [7:0] byte_out, byte_index, pdu_len;
  logic [3:0] pdu_type;
  logic       byte_valid, hdr_valid, pkt_done, crc_ok, len_err, pkt_abort;
`ifdef BLE_DEFRAMER_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  ble_pdu_deframer #(
    .BIT_PERIOD(BIT_PERIOD), .SAMPLE_OFFSET(SAMPLE_OFFSET),
    .MAX_LEN(MAX_LEN), .CRC_INIT(CRC_INIT)
  ) dut (
    .clock(clock), .reset(reset), .trigger(trigger), .bit_in(bit_in),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_index(byte_index),
    .hdr_valid(hdr_valid), .pdu_type(pdu_type), .pdu_len(pdu_len),
    .pkt_done(pkt_done), .crc_ok(crc_ok), .len_err(len_err),
`ifdef BLE_DEFRAMER_ERR_CNT_EN
    .err_count(err_count),
`endif
    .pkt_abort(pkt_abort)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] a;
    logic [7:0] b;
  } ev_t;

  ev_t        q_byte[$];
  ev_t        q_hdr[$];
  ev_t        q_done[$];
  ev_t        q_abort[$];
  logic [7:0] pkt[$];
  bit         tx[$];
  int         t0;
  int         exp_err = 0;
  int         total = 0;
  int         bad = 0;

  // Edge (cycle count) at which bit i of the current window is sampled.
  function automatic int due_of(input int i);
    return t0 + 1 + SAMPLE_OFFSET + BIT_PERIOD * i;
  endfunction

  function automatic logic [23:0] model_crc();
    logic [23:0] c;
    logic        fb;
    c = CRC_INIT;
    foreach (pkt[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[23] ^ pkt[k][i];
        c  = {c[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h000000);
      end
    end
    return c;
  endfunction

  function automatic int pending();
    return q_byte.size() + q_hdr.size() + q_done.size() + q_abort.size();
  endfunction

  task automatic push_ev(input int kind, input int due, input logic [7:0] a, input logic [7:0] b);
    ev_t e;
    e.due = due; e.a = a; e.b = b;
    case (kind)
      0: q_byte.push_back(e);
      1: q_hdr.push_back(e);
      2: q_done.push_back(e);
      default: q_abort.push_back(e);
    endcase
  endtask

  // Serialise pkt (LSB first) followed by the CRC (MSB first), optionally corrupted.
  task automatic build_tx(input logic [23:0] flip);
    logic [23:0] c;
    tx.delete();
    foreach (pkt[k]) for (int i = 0; i < 8; i++) tx.push_back(pkt[k][i]);
    c = model_crc() ^ flip;
    for (int i = 23; i >= 0; i--) tx.push_back(c[i]);
  endtask

  task automatic expect_full(input logic ok);
    int n;
    n = pkt.size();
    for (int k = 0; k < n; k++) push_ev(0, due_of(8 * k + 7), 8'(k), pkt[k]);
    push_ev(1, due_of(15), {4'd0, pkt[0][3:0]}, pkt[1]);
    push_ev(2, due_of(8 * n + 23), {7'd0, ok}, 8'd0);
  endtask

  task automatic start_window();
    @(posedge clock); #1;
    trigger = 1'b1;
    t0 = cyc;
  endtask

  // bit_in carries the wanted bit only in the cycle before the sample edge and its inverse otherwise.
  task automatic run_bits(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      for (int c = 0; c < BIT_PERIOD; c++) begin
        bit_in = (c == SAMPLE_OFFSET) ? tx[i] : !tx[i];
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic end_window();
    trigger = 1'b0;
    bit_in  = 1'b0;
    repeat (20) @(posedge clock);
    #1;
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clock);
      if (byte_valid === 1'b1) begin
        total++;
        if (q_byte.size() == 0) begin
          bad++;
          $display("FAIL byte_unexpected: got idx=%0d data=0x%02h at cyc %0d, required no strobe", byte_index, byte_out, cyc);
        end else begin
          e = q_byte.pop_front();
          if (byte_index !== e.a || byte_out !== e.b || cyc != e.due) begin
            bad++;
            $display("FAIL byte: got idx=%0d data=0x%02h cyc=%0d, required idx=%0d data=0x%02h cyc=%0d",
                     byte_index, byte_out, cyc, e.a, e.b, e.due);
          end
        end
      end
      if (hdr_valid === 1'b1) begin
        total++;
        if (q_hdr.size() == 0) begin
          bad++;
          $display("FAIL hdr_unexpected: got type=%0d len=%0d at cyc %0d, required no strobe", pdu_type, pdu_len, cyc);
        end else begin
          e = q_hdr.pop_front();
          if ({4'd0, pdu_type} !== e.a || pdu_len !== e.b || cyc != e.due) begin
            bad++;
            $display("FAIL hdr: got type=%0d len=%0d cyc=%0d, required type=%0d len=%0d cyc=%0d",
                     pdu_type, pdu_len, cyc, e.a, e.b, e.due);
          end
        end
      end
      if (pkt_done === 1'b1) begin
        total++;
        if (q_done.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected: got pkt_done at cyc %0d, required no strobe", cyc);
        end else begin
          e = q_done.pop_front();
          if (!e.a[0] || e.b[0]) begin
            if (exp_err < 65535) exp_err++;
          end
          if (crc_ok !== e.a[0] || len_err !== e.b[0] || cyc != e.due) begin
            bad++;
            $display("FAIL done: got crc_ok=%b len_err=%b cyc=%0d, required crc_ok=%b len_err=%b cyc=%0d",
                     crc_ok, len_err, cyc, e.a[0], e.b[0], e.due);
          end
`ifdef BLE_DEFRAMER_ERR_CNT_EN
          total++;
          if (err_count !== 16'(exp_err)) begin
            bad++;
            $display("FAIL err_count: got %0d, required %0d", err_count, exp_err);
          end
`endif
        end
      end
      if (pkt_abort === 1'b1) begin
        total++;
        if (q_abort.size() == 0) begin
          bad++;
          $display("FAIL abort_unexpected: got pkt_abort at cyc %0d, required no strobe", cyc);
        end else begin
          e = q_abort.pop_front();
          if (cyc != e.due || crc_ok !== 1'b0 || len_err !== 1'b0) begin
            bad++;
            $display("FAIL abort: got cyc=%0d crc_ok=%b len_err=%b, required cyc=%0d crc_ok=0 len_err=0",
                     cyc, crc_ok, len_err, e.due);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [33:0] obs;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    obs = {byte_out, byte_valid, byte_index, hdr_valid, pdu_type, pdu_len, pkt_done, crc_ok, len_err, pkt_abort};
    total++;
    if (obs !== 34'd0) begin
      bad++;
      $display("FAIL reset_outputs: got 0x%09h, required 0", obs);
    end
`ifdef BLE_DEFRAMER_ERR_CNT_EN
    total++;
    if (err_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_err_count: got %0d, required 0", err_count);
    end
`endif
    reset = 1'b1;
  endtask

  task automatic test_good_packet();
    pkt = '{8'h02, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    build_tx(24'h0);
    start_window();
    expect_full(1'b1);
    run_bits(0, tx.size());
    end_window();
    total++;
    if (pending() != 0 || crc_ok !== 1'b1 || len_err !== 1'b0) begin
      bad++;
      $display("FAIL good_packet: got pending=%0d crc_ok=%b len_err=%b, required pending=0 crc_ok=1 len_err=0",
               pending(), crc_ok, len_err);
    end
  endtask

  task automatic test_bad_crc();
    pkt = '{8'h02, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    build_tx(24'h000020);
    start_window();
    expect_full(1'b0);
    run_bits(0, tx.size());
    end_window();
    total++;
    if (pending() != 0 || crc_ok !== 1'b0 || len_err !== 1'b0) begin
      bad++;
      $display("FAIL bad_crc: got pending=%0d crc_ok=%b len_err=%b, required pending=0 crc_ok=0 len_err=0",
               pending(), crc_ok, len_err);
    end
  endtask

  task automatic test_len_error();
    pkt = '{8'h00, 8'h26};
    tx.delete();
    foreach (pkt[k]) for (int i = 0; i < 8; i++) tx.push_back(pkt[k][i]);
    for (int i = 0; i < 16; i++) tx.push_back(1'($urandom_range(0, 1)));
    start_window();
    push_ev(0, due_of(7), 8'd0, 8'h00);
    push_ev(0, due_of(15), 8'd1, 8'h26);
    push_ev(1, due_of(15), 8'd0, 8'h26);
    push_ev(2, due_of(15), 8'd0, 8'd1);
    run_bits(0, tx.size());
    end_window();
    total++;
    if (pending() != 0 || crc_ok !== 1'b0 || len_err !== 1'b1) begin
      bad++;
      $display("FAIL len_error: got pending=%0d crc_ok=%b len_err=%b, required pending=0 crc_ok=0 len_err=1",
               pending(), crc_ok, len_err);
    end
  endtask

  task automatic test_zero_len();
    pkt = '{8'h04, 8'h00};
    build_tx(24'h0);
    start_window();
    expect_full(1'b1);
    run_bits(0, tx.size());
    end_window();
    total++;
    if (pending() != 0 || crc_ok !== 1'b1 || len_err !== 1'b0) begin
      bad++;
      $display("FAIL zero_len: got pending=%0d crc_ok=%b len_err=%b, required pending=0 crc_ok=1 len_err=0",
               pending(), crc_ok, len_err);
    end
  endtask

  // Trigger falls on the sample edge of the first bit of payload byte 3: abort wins, bit not taken.
  task automatic test_abort();
    pkt = '{8'h02, 8'h05, 8'hA5, 8'h3C, 8'h7E, 8'h11, 8'h99};
    build_tx(24'h0);
    start_window();
    for (int k = 0; k < 5; k++) push_ev(0, due_of(8 * k + 7), 8'(k), pkt[k]);
    push_ev(1, due_of(15), 8'd2, 8'h05);
    run_bits(0, 40);
    for (int c = 0; c < SAMPLE_OFFSET; c++) begin
      bit_in = !tx[40];
      @(posedge clock); #1;
    end
    trigger = 1'b0;
    bit_in  = tx[40];
    push_ev(3, cyc + 1, 8'd0, 8'd0);
    @(posedge clock); #1;
    end_window();
    total++;
    if (pending() != 0 || crc_ok !== 1'b0 || len_err !== 1'b0) begin
      bad++;
      $display("FAIL abort_end: got pending=%0d crc_ok=%b len_err=%b, required pending=0 crc_ok=0 len_err=0",
               pending(), crc_ok, len_err);
    end
  endtask

  task automatic test_back_to_back();
    pkt = '{8'h01, 8'h03, 8'hDE, 8'hAD, 8'hBE};
    build_tx(24'h0);
    start_window();
    expect_full(1'b1);
    run_bits(0, tx.size());
    end_window();
    total++;
    if (pending() != 0 || crc_ok !== 1'b1) begin
      bad++;
      $display("FAIL back_to_back: got pending=%0d crc_ok=%b, required pending=0 crc_ok=1", pending(), crc_ok);
    end
  endtask

  task automatic test_reset_mid_payload();
    logic [33:0] obs;
    pkt = '{8'h02, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    build_tx(24'h0);
    start_window();
    for (int k = 0; k < 3; k++) push_ev(0, due_of(8 * k + 7), 8'(k), pkt[k]);
    push_ev(1, due_of(15), 8'd2, 8'h06);
    run_bits(0, 30);
    reset   = 1'b0;
    trigger = 1'b0;
    bit_in  = 1'b0;
    @(posedge clock); #1;
    obs = {byte_out, byte_valid, byte_index, hdr_valid, pdu_type, pdu_len, pkt_done, crc_ok, len_err, pkt_abort};
    total++;
    if (obs !== 34'd0) begin
      bad++;
      $display("FAIL reset_mid_payload: got 0x%09h, required 0", obs);
    end
`ifdef BLE_DEFRAMER_ERR_CNT_EN
    total++;
    if (err_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_mid_err_count: got %0d, required 0", err_count);
    end
`endif
    exp_err = 0;
    reset   = 1'b1;
    repeat (3 * BIT_PERIOD) @(posedge clock);
    #1;
    total++;
    if (pending() != 0) begin
      bad++;
      $display("FAIL reset_mid_pending: got %0d outstanding, required 0", pending());
    end
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL timeout: got no completion by cyc %0d, required completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_good_packet();
    test_bad_crc();
    test_len_error();
    test_zero_len();
    test_abort();
    test_back_to_back();
    test_reset_mid_payload();
    test_good_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
